// File: rtl/ex_div_pkg.sv
// Shared widths, ALU op codes and helpers for the EX-stage divider.
// Build option: DIV_EARLY_OUT_EN (divide-by-zero / signed overflow bypass the iteration).
package ex_div_pkg;

   localparam int REG_W   = 32;
   localparam int ALUOP_W = 8;

   localparam logic [REG_W-1:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic             RST_ENABLE = 1'b1;

   localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;
   localparam logic [ALUOP_W-1:0] EXE_REM_OP  = 8'b0001_1100;
   localparam logic [ALUOP_W-1:0] EXE_REMU_OP = 8'b0001_1101;

   function automatic logic is_div_family(input logic [ALUOP_W-1:0] op);
      case (op)
         EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP: is_div_family = 1'b1;
         default:                                          is_div_family = 1'b0;
      endcase
   endfunction

   function automatic logic is_signed_op(input logic [ALUOP_W-1:0] op);
      case (op)
         EXE_DIV_OP, EXE_REM_OP: is_signed_op = 1'b1;
         default:                is_signed_op = 1'b0;
      endcase
   endfunction

   // Quotient-producing ops; the rest return the remainder.
   function automatic logic is_quot_op(input logic [ALUOP_W-1:0] op);
      case (op)
         EXE_DIV_OP, EXE_DIVU_OP: is_quot_op = 1'b1;
         default:                 is_quot_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
module div_step
   import ex_div_pkg::*;
(
   input  logic [REG_W-1:0] rem,
   input  logic [REG_W-1:0] quo,
   input  logic [REG_W-1:0] divisor,
   output logic [REG_W-1:0] rem_next,
   output logic [REG_W-1:0] quo_next
);

   logic [REG_W:0] partial_s;
   logic [REG_W:0] diff_s;

   // Restoring step; partial stays below 2*divisor so 33 bits suffice.
   always_comb begin
      partial_s = {rem, quo[REG_W-1]};
      diff_s    = partial_s - {1'b0, divisor};
      if (diff_s[REG_W] == 1'b0) begin
         rem_next = diff_s[REG_W-1:0];
         quo_next = {quo[REG_W-2:0], 1'b1};
      end else begin
         rem_next = partial_s[REG_W-1:0];
         quo_next = {quo[REG_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle EX-stage divider (DIV/DIVU/REM/REMU) with pipeline stall and flush.
// Build option: DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow IDLE -> DONE.
module ex_div
   import ex_div_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [REG_W-1:0]   reg1,
   input  logic [REG_W-1:0]   reg2,
   input  logic               annul,
   output logic               stallreq,
   output logic [REG_W-1:0]   result,
   output logic               ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t             state_r, state_s;
   logic [5:0]         cnt_r, cnt_s;
   logic [REG_W-1:0]   rem_r, rem_s, quo_r, quo_s, dsr_r, dsr_s;
   logic [ALUOP_W-1:0] op_r, op_s;
   logic               neg_q_r, neg_q_s, neg_rem_r, neg_rem_s, dz_r, dz_s;
   logic [REG_W-1:0]   result_r, result_s;
   logic               ready_r, ready_s;

   logic [REG_W-1:0]   step_rem_s, step_quo_s;
   logic               a_neg_s, b_neg_s, dz_in_s, ovf_in_s, early_hit_s;
   logic [REG_W-1:0]   abs_a_s, abs_b_s, early_val_s, quo_fix_s, rem_fix_s, final_s;

   div_step u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (dsr_r),
      .rem_next (step_rem_s),
      .quo_next (step_quo_s)
   );

   // Operand magnitudes, special-case detection and final sign fix-up.
   always_comb begin
      a_neg_s     = is_signed_op(aluop) & reg1[REG_W-1];
      b_neg_s     = is_signed_op(aluop) & reg2[REG_W-1];
      abs_a_s     = a_neg_s ? (ZERO_WORD - reg1) : reg1;
      abs_b_s     = b_neg_s ? (ZERO_WORD - reg2) : reg2;
      dz_in_s     = (reg2 == ZERO_WORD);
      ovf_in_s    = is_signed_op(aluop) && (reg1 == 32'h8000_0000) && (reg2 == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
      early_hit_s = dz_in_s | ovf_in_s;
`else
      early_hit_s = 1'b0;
`endif
      if (dz_in_s) begin
         early_val_s = is_quot_op(aluop) ? 32'hFFFF_FFFF : reg1;
      end else begin
         early_val_s = is_quot_op(aluop) ? 32'h8000_0000 : ZERO_WORD;
      end
      // A zero divisor yields all-ones quotient regardless of the dividend sign.
      quo_fix_s = dz_r ? 32'hFFFF_FFFF : (neg_q_r ? (ZERO_WORD - step_quo_s) : step_quo_s);
      rem_fix_s = neg_rem_r ? (ZERO_WORD - step_rem_s) : step_rem_s;
      final_s   = is_quot_op(op_r) ? quo_fix_s : rem_fix_s;
   end

   // Stall request is combinational so the pipeline freezes in the start cycle itself.
   always_comb begin
      stallreq = (rst != RST_ENABLE) &&
                 ((state_r == BUSY) ||
                  ((state_r == IDLE) && start && !annul && is_div_family(aluop)));
   end

   // Next-state, datapath and output-register logic.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      rem_s     = rem_r;
      quo_s     = quo_r;
      dsr_s     = dsr_r;
      op_s      = op_r;
      neg_q_s   = neg_q_r;
      neg_rem_s = neg_rem_r;
      dz_s      = dz_r;
      ready_s   = 1'b0;
      result_s  = ZERO_WORD;
      if (annul) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start && is_div_family(aluop)) begin
                  cnt_s     = 6'd0;
                  rem_s     = ZERO_WORD;
                  quo_s     = abs_a_s;
                  dsr_s     = abs_b_s;
                  op_s      = aluop;
                  neg_q_s   = a_neg_s ^ b_neg_s;
                  neg_rem_s = a_neg_s;
                  dz_s      = dz_in_s;
                  if (early_hit_s) begin
                     state_s  = DONE;
                     ready_s  = 1'b1;
                     result_s = early_val_s;
                  end else begin
                     state_s  = BUSY;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            BUSY: begin
               rem_s = step_rem_s;
               quo_s = step_quo_s;
               cnt_s = cnt_r + 6'd1;
               if (cnt_r == 6'd31) begin
                  state_s  = DONE;
                  ready_s  = 1'b1;
                  result_s = final_s;
               end else begin
                  state_s  = BUSY;
               end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_r   <= IDLE;
         cnt_r     <= 6'd0;
         rem_r     <= ZERO_WORD;
         quo_r     <= ZERO_WORD;
         dsr_r     <= ZERO_WORD;
         op_r      <= 8'h00;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         dz_r      <= 1'b0;
         ready_r   <= 1'b0;
         result_r  <= ZERO_WORD;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         rem_r     <= rem_s;
         quo_r     <= quo_s;
         dsr_r     <= dsr_s;
         op_r      <= op_s;
         neg_q_r   <= neg_q_s;
         neg_rem_r <= neg_rem_s;
         dz_r      <= dz_s;
         ready_r   <= ready_s;
         result_r  <= result_s;
      end
   end

   assign ready  = ready_r;
   assign result = result_r;

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset (RstEnable), sampled only on posedge clk.
REQ-003 SHALL have port start  input  1  EX stage holds a divide/remainder op; level, stable while stallreq high.
REQ-004 SHALL have port aluop  input  AluOpBus  EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP or EXE_REMU_OP.
REQ-005 SHALL have port reg1  input  RegBus  dividend, taken from ex_reg1.
REQ-006 SHALL have port reg2  input  RegBus  divisor, taken from ex_reg2.
REQ-007 SHALL have port annul  input  1  pipeline flush; abandons the operation in progress.
REQ-008 SHALL have port stallreq  output  1  request to freeze IF/ID/EX until the result is ready.
REQ-009 SHALL have port result  output  RegBus  quotient or remainder, valid only while ready high.
REQ-010 SHALL have port ready  output  1  one-cycle result-valid strobe.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-012 IDLE: start=1 and annul=0 SHALL latch |reg1|, |reg2| (signed ops) or raw values (unsigned), the op, and the sign flags; SHALL clear the 6-bit counter and enter BUSY.
REQ-013 BUSY: SHALL perform one radix-2 restoring step per cycle (shift remainder left, trial-subtract divisor, set quotient bit when non-negative) and increment the counter.
REQ-014 BUSY SHALL go to DONE after the 32nd step, i.e. latency 33 cycles from the start-sampling edge to ready=1.
REQ-015 DONE: ready=1 for exactly one cycle, then IDLE; start is ignored in DONE.
REQ-016 stallreq SHALL equal (IDLE and start and !annul) or BUSY; it is 0 in DONE so the pipeline advances on the edge ending DONE.
REQ-017 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the dividend's sign.
REQ-018 Divisor zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL equal the dividend, for both signed and unsigned ops.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient SHALL be 0x80000000 and remainder SHALL be 0.
REQ-020 annul=1 in any state SHALL force IDLE on the next edge with ready=0 and stallreq=0; annul has priority over start.
REQ-021 result SHALL be ZeroWord whenever ready=0.
REQ-022 A non-divide aluop with start=1 SHALL be ignored (stay IDLE, stallreq=0).

Reset
REQ-023 rst=1 SHALL force state IDLE, counter 0, internal registers ZeroWord, stallreq=0, ready=0, result=ZeroWord, overriding annul and start, including mid-operation.

Configuration
REQ-024 With DIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow SHALL skip BUSY (IDLE -> DONE), giving latency 1 cycle with the REQ-018/019 values.
REQ-025 Without DIV_EARLY_OUT_EN, these cases SHALL take the full 33 cycles and still return the REQ-018/019 values.

Structure
REQ-026 AluOp codes, RegBus/AluOpBus widths, ZeroWord and RstEnable SHALL come from the shared defines header; state encodings SHALL be local parameters.
REQ-027 The per-cycle subtract/shift step SHALL be a combinational sub-module div_step; sign fix-up and FSM SHALL stay in ex_div.

Verification
REQ-028 DIV 100 / 7, start held -> stallreq high 33 cycles, ready at T+33 with result 14 (0x0000000E).
REQ-029 REM -7 / 2 -> result 0xFFFFFFFF (-1); REMU 0xFFFFFFF9 / 2 -> result 1.
REQ-030 DIVU 5 / 0 -> result 0xFFFFFFFF; ready at T+1 with DIV_EARLY_OUT_EN, at T+33 without.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM of the same operands -> result 0.
REQ-032 annul at BUSY cycle 10 -> IDLE next edge, stallreq 0, no ready pulse; a following DIV 9 / 3 returns 3.
REQ-033 rst during BUSY -> all outputs zero next cycle; a subsequent DIVU 20 / 4 returns 5 after 33 cycles.
